// File: rtl/audio_buf_pkg.sv
// Shared types and constants for the delay-line sample buffer and its
// neighbouring audio stages.
package audio_buf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWt,
        StCap,
        StWr,
        StOut
    } state_e;

    // Cycles from the address edge to valid read data at the RAM port.
    localparam int unsigned RAM_RD_LATENCY = 2;

    localparam logic [15:0] SAMPLE_MAX = 16'h7FFF;
    localparam logic [15:0] SAMPLE_MIN = 16'h8000;

endpackage

// File: rtl/sample_sat_mix.sv
// Combinational saturating add: a + (b >>> SHIFT), clamped to the signed
// DATA_WIDTH range.
module sample_sat_mix #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SHIFT      = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] b_shr;
    logic [DATA_WIDTH:0]   sum;

    always_comb begin
        b_shr = $signed(b) >>> SHIFT;
        sum   = {a[DATA_WIDTH-1], a} + {b_shr[DATA_WIDTH-1], b_shr};
        // Top two bits disagree only on overflow; the top bit gives the true sign.
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            y = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            y = sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/audio_delay_ctrl.sv
// Delay-line sequencer in front of a single-port sample RAM: reads the sample
// DELAY positions back, writes the new one, and emits delayed or echo-mixed audio.
module audio_delay_ctrl
    import audio_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MIX_SHIFT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_in_valid,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic                  mix_en,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] s_q;
    logic [DATA_WIDTH-1:0] dly_q;
    logic [ADDR_WIDTH:0]   d_q;
    logic                  m_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   fill_q;

    logic [ADDR_WIDTH:0]   delay_ext;
    logic [DATA_WIDTH-1:0] mix_out;

    // A zero delay selects the full buffer depth.
    assign delay_ext = (delay == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, delay};
    assign busy      = (state_q != StIdle);

    sample_sat_mix #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (MIX_SHIFT)
    ) u_mix (
        .a (s_q),
        .b (dly_q),
        .y (mix_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            s_q              <= '0;
            dly_q            <= '0;
            d_q              <= '0;
            m_q              <= 1'b0;
            wr_ptr_q         <= '0;
            fill_q           <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overrun          <= 1'b0;
            ram_addr         <= '0;
            ram_wr_data      <= '0;
            ram_wr_en        <= 1'b0;
        end else begin
            sample_out_valid <= 1'b0;
            ram_wr_en        <= 1'b0;
            overrun          <= sample_in_valid && (state_q != StIdle);

            case (state_q)
                StIdle: begin
                    if (sample_in_valid) begin
                        s_q      <= sample_in;
                        d_q      <= delay_ext;
                        m_q      <= mix_en;
                        // Address is registered here so it is on the bus during RD.
                        ram_addr <= wr_ptr_q - delay_ext[ADDR_WIDTH-1:0];
                        state_q  <= StRd;
                    end
                end
                StRd: state_q <= StWt;
                StWt: state_q <= StCap;
                StCap: begin
                    dly_q       <= (fill_q < d_q) ? '0 : ram_rd_data;
                    ram_addr    <= wr_ptr_q;
                    ram_wr_data <= s_q;
                    ram_wr_en   <= 1'b1;
                    state_q     <= StWr;
                end
                StWr: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (!fill_q[ADDR_WIDTH]) begin
                        fill_q <= fill_q + 1'b1;
                    end
                    sample_out       <= m_q ? mix_out : dly_q;
                    sample_out_valid <= 1'b1;
                    state_q          <= StOut;
                end
                StOut:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_delay_ctrl.sv
// Scoreboard bench for audio_delay_ctrl with a behavioural 512x16 RAM
// (registered output, two-cycle read latency).
module tb_audio_delay_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [8:0]  delay;
    logic        mix_en;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        busy;
    logic        overrun;
    logic [8:0]  ram_addr;
    logic [15:0] ram_wr_data;
    logic        ram_wr_en;
    logic [15:0] ram_rd_data;

    audio_delay_ctrl #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (16),
        .MIX_SHIFT  (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .delay            (delay),
        .mix_en           (mix_en),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun),
        .ram_addr         (ram_addr),
        .ram_wr_data      (ram_wr_data),
        .ram_wr_en        (ram_wr_en),
        .ram_rd_data      (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; unwritten words hold a non-zero pattern.
    logic [15:0] mem [512];
    logic [15:0] rd_q1, rd_q2;
    initial for (int i = 0; i < 512; i++) mem[i] = 16'hBEEF;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
        rd_q1 <= mem[ram_addr];
        rd_q2 <= rd_q1;
    end
    assign ram_rd_data = rd_q2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int exp_wptr = 0;
    int wr0;

    logic [15:0] oq_data [$];
    int          oq_cyc  [$];
    logic [8:0]  wq_addr [$];
    logic [15:0] wq_data [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected writes and outputs whenever the DUT presents them.
    always @(negedge clk) begin : monitor
        logic [15:0] ed;
        logic [8:0]  ea;
        int          ec;
        if (!rst) begin
            if (ram_wr_en) begin
                wr_cnt++;
                if (wq_addr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", ram_addr, ram_wr_data);
                end else begin
                    ea = wq_addr.pop_front();
                    ed = wq_data.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(ea));
                    check("wr_data", 32'(ram_wr_data), 32'(ed));
                end
            end
            if (sample_out_valid) begin
                if (oq_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got 0x%0h, none expected", sample_out);
                end else begin
                    ed = oq_data.pop_front();
                    ec = oq_cyc.pop_front();
                    check("sample_out", 32'(sample_out), 32'(ed));
                    check("latency", 32'(cyc), 32'(ec + 5));
                end
            end
        end
    end

    task automatic send(input logic [15:0] s, input logic [8:0] d, input logic m,
                        input logic [15:0] exp, input int gap);
        sample_in       = s;
        delay           = d;
        mix_en          = m;
        sample_in_valid = 1'b1;
        oq_data.push_back(exp);
        oq_cyc.push_back(cyc);
        wq_addr.push_back(9'(exp_wptr));
        wq_data.push_back(s);
        exp_wptr = (exp_wptr + 1) % 512;
        step;
        sample_in_valid = 1'b0;
        repeat (gap - 1) step;
    endtask

    task automatic do_reset;
        check("drained_before_reset", 32'(oq_data.size()), 32'd0);
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
        exp_wptr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        sample_in       = '0;
        sample_in_valid = 1'b0;
        delay           = '0;
        mix_en          = 1'b0;
        step;
        step;
        @(negedge clk);
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_out_valid", 32'(sample_out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wr_data", 32'(ram_wr_data), 32'd0);
        step;
        rst = 1'b0;
        step;

        // Pure delay of 4.
        send(16'd1, 9'd4, 1'b0, 16'd0, 8);
        send(16'd2, 9'd4, 1'b0, 16'd0, 8);
        send(16'd3, 9'd4, 1'b0, 16'd0, 8);
        send(16'd4, 9'd4, 1'b0, 16'd0, 8);
        send(16'd5, 9'd4, 1'b0, 16'd1, 8);
        send(16'd6, 9'd4, 1'b0, 16'd2, 8);
        send(16'd7, 9'd4, 1'b0, 16'd3, 8);
        send(16'd8, 9'd4, 1'b0, 16'd4, 8);

        // Full-depth delay at minimum spacing; pointer wraps on the 513th write.
        do_reset;
        for (int n = 1; n <= 513; n++) begin
            send(16'(n), 9'd0, 1'b0, (n == 513) ? 16'd1 : 16'd0, 6);
        end
        step;
        step;

        // Saturation, positive then negative.
        do_reset;
        send(16'h7000, 9'd1, 1'b1, 16'h7000, 8);
        send(16'h7000, 9'd1, 1'b1, 16'h7FFF, 8);
        do_reset;
        send(16'h9000, 9'd1, 1'b1, 16'h9000, 8);
        send(16'h9000, 9'd1, 1'b1, 16'h8000, 8);

        // Strobe while busy is dropped.
        do_reset;
        wr0 = wr_cnt;
        sample_in       = 16'h0042;
        delay           = 9'd3;
        mix_en          = 1'b0;
        sample_in_valid = 1'b1;
        oq_data.push_back(16'd0);
        oq_cyc.push_back(cyc);
        wq_addr.push_back(9'(exp_wptr));
        wq_data.push_back(16'h0042);
        exp_wptr = exp_wptr + 1;
        step;
        sample_in_valid = 1'b0;
        step;
        @(negedge clk);
        check("no_overrun_before", 32'(overrun), 32'd0);
        sample_in       = 16'h5555;
        sample_in_valid = 1'b1;
        step;
        sample_in_valid = 1'b0;
        @(negedge clk);
        check("overrun_pulse", 32'(overrun), 32'd1);
        check("busy_during_seq", 32'(busy), 32'd1);
        step;
        @(negedge clk);
        check("overrun_one_cycle", 32'(overrun), 32'd0);
        repeat (6) step;
        check("single_write", 32'(wr_cnt - wr0), 32'd1);
        check("busy_after_seq", 32'(busy), 32'd0);

        // Reset during WT aborts the in-flight sample.
        do_reset;
        send(16'h1111, 9'd1, 1'b1, 16'h1111, 8);
        wr0 = wr_cnt;
        sample_in       = 16'h2222;
        sample_in_valid = 1'b1;
        step;
        sample_in_valid = 1'b0;
        step;
        rst = 1'b1;
        step;
        @(negedge clk);
        check("abort_sample_out", 32'(sample_out), 32'd0);
        check("abort_out_valid", 32'(sample_out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_en", 32'(ram_wr_en), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        check("abort_wr_data", 32'(ram_wr_data), 32'd0);
        step;
        rst = 1'b0;
        exp_wptr = 0;
        repeat (6) step;
        check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
        send(16'h3333, 9'd1, 1'b0, 16'd0, 8);

        // Echo mix with delay 2.
        do_reset;
        send(16'd100, 9'd2, 1'b1, 16'd100, 8);
        send(16'd200, 9'd2, 1'b1, 16'd200, 8);
        send(16'd300, 9'd2, 1'b1, 16'd350, 8);

        repeat (4) step;
        check("outputs_drained", 32'(oq_data.size()), 32'd0);
        check("writes_drained", 32'(wq_addr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_delay_ctrl.md
Name: audio_delay_ctrl

Overview:
- Sequencer directly upstream of the 512x16 single-port sample RAM (registered output, NORMAL_WRITE) in the WM8731 audio path.
- Accepts one 16-bit signed PCM sample per strobe from the I2S receive stage.
- For each sample it reads the sample stored DELAY positions earlier, then writes the new sample at the write pointer.
- Emits either the delayed sample alone or an echo mix (input + attenuated delayed sample) to the I2S transmit stage.

Parameters:
- ADDR_WIDTH, 9: RAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16: sample width, two's complement.
- MIX_SHIFT, 1: arithmetic right shift applied to the delayed sample before mixing.

Ports:
- clk  in  1  system clock; also clocks the RAM.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_WIDTH  incoming PCM sample.
- sample_in_valid  in  1  one-cycle strobe qualifying sample_in.
- delay  in  ADDR_WIDTH  delay in samples; 0 means 2^ADDR_WIDTH.
- mix_en  in  1  1 = echo mix output, 0 = pure delayed output.
- sample_out  out  DATA_WIDTH  processed sample.
- sample_out_valid  out  1  one-cycle strobe qualifying sample_out.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  one-cycle pulse when a strobe is dropped.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_wr_en  out  1  RAM write enable.
- ram_rd_data  in  DATA_WIDTH  RAM read data; 2-cycle latency from the address edge.

Behaviour:
- Reset (sync, rst=1 at edge):
  - FSM to IDLE; wr_ptr=0, fill_cnt=0.
  - sample_out=0, sample_out_valid=0, busy=0, overrun=0, ram_wr_en=0, ram_addr=0, ram_wr_data=0.
  - Reset mid-operation aborts the sequence. No write is issued; the in-flight sample is lost.
- IDLE, on sample_in_valid:
  - Latch sample_in to s_reg, delay to d_reg (0 maps to 2^ADDR_WIDTH), mix_en to m_reg.
  - Go to RD.
- RD:
  - ram_addr = (wr_ptr - d_reg) mod 2^ADDR_WIDTH; ram_wr_en=0.
  - Go to WT.
- WT: no RAM access; go to CAP.
- CAP:
  - Capture ram_rd_data into dly_reg.
  - If fill_cnt < d_reg, force dly_reg=0 (the location has not been written yet).
  - Go to WR.
- WR:
  - ram_addr=wr_ptr, ram_wr_data=s_reg, ram_wr_en=1 for exactly this cycle.
  - wr_ptr increments and wraps 511->0.
  - fill_cnt (ADDR_WIDTH+1 bits) increments and saturates at 2^ADDR_WIDTH.
  - Go to OUT.
- OUT:
  - sample_out = m_reg ? sat(s_reg + (dly_reg >>> MIX_SHIFT)) : dly_reg.
  - sample_out_valid=1 for one cycle. Go to IDLE.
- Latency: sample_in_valid in cycle 0 gives sample_out_valid in cycle 5. Minimum sample spacing is 6 cycles.
- Arithmetic:
  - Sum is computed at DATA_WIDTH+1 bits.
  - Clamp to 0x7FFF / 0x8000 on positive / negative overflow.
- busy = (state != IDLE).
- sample_in_valid while busy: sample ignored, overrun pulses the next cycle, FSM unaffected.
- sample_in_valid in the OUT cycle is also dropped. It is accepted only in IDLE.
- delay and mix_en changes take effect only at the next accepted sample.
- ram_wr_en is never high outside WR.
- ram_addr holds its last value in IDLE, WT, CAP and OUT.

Decomposition:
- Package audio_buf_pkg:
  - FSM state enum (IDLE, RD, WT, CAP, WR, OUT).
  - RAM_RD_LATENCY=2.
  - SAMPLE_MAX=16'h7FFF, SAMPLE_MIN=16'h8000.
- Sub-module sample_sat_mix: combinational saturating add of a sample and a shifted sample. It is reused by the later volume and mixer stages.

Test Plan:
- Reset, then delay=4, mix_en=0, samples 1..8 spaced 8 cycles -> outputs 0,0,0,0,1,2,3,4; each output 5 cycles after its strobe.
- delay=0, 513 samples of value n -> outputs 0 for n<512; sample 513 yields 1. wr_ptr wraps 511->0 with ram_addr=0 on the WR cycle.
- mix_en=1, delay=1, samples 0x7000 then 0x7000 -> second output saturates to 0x7FFF. Repeat with 0x9000,0x9000 -> 0x8000.
- Strobe at cycle 0 and again at cycle 2 -> overrun pulse at cycle 3, single sample_out_valid at cycle 5, exactly one ram_wr_en cycle.
- rst asserted during WT -> next cycle all outputs 0, no ram_wr_en. A following sample with delay=1 outputs 0 (fill_cnt cleared).
- mix_en=1, delay=2, samples 100,200,300 -> outputs 100,200,350.
